mc_controller: RTL and testbench
================================

MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 Parameter TIMEOUT_CYC, default 16: maximum number of cycles to wait for mem_ready in any memory state.
REQ-002 clk  in  1  single clock; all state changes on the rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 op  in  6  instruction opcode, taken from the instruction register.
REQ-005 funct  in  6  R-type function field, taken from the instruction register.
REQ-006 zero  in  1  ALU zero flag.
REQ-007 mem_ready  in  1  memory access complete, sampled in the current cycle.
REQ-008 mem_req  out  1  memory access request.
REQ-009 iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca  out  1 each  datapath controls.
REQ-010 alusrcb  out  2  ALU B-operand select: 00 rt, 01 constant 4, 10 sign-extended immediate, 11 immediate shifted left by 2.
REQ-011 pcsrc  out  2  PC source select: 00 ALU result, 01 ALUOut, 10 jump target.
REQ-012 pcen  out  1  PC write enable.
REQ-013 alucontrol  out  5  ALU operation.
REQ-014 illegal_op  out  1  one-cycle pulse on an unsupported opcode.
REQ-015 mem_timeout  out  1  one-cycle pulse when a memory access is abandoned.

Function
REQ-016 The block SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP.
REQ-017 FETCH: mem_req=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00.
- Hold in FETCH until mem_ready=1.
- In that cycle: irwrite=1 and pcwrite=1, then go to DECODE.
REQ-018 DECODE: alusrca=0, alusrcb=11, aluop=00. Next state by op:
- 100011 or 101011 -> MEMADR
- 000000 -> EXEC
- 000100 -> BRANCH
- 001000 -> ADDIEX
- 000010 -> JUMP
- any other op -> FETCH with illegal_op=1
REQ-019 MEMADR: alusrca=1, alusrcb=10, aluop=00; next MEMRD if op=100011, else MEMWR.
REQ-020 MEMRD: mem_req=1, iord=1; hold until mem_ready=1, then go to MEMWB.
REQ-021 MEMWB: regdst=0, memtoreg=1, regwrite=1; then FETCH.
REQ-022 MEMWR: mem_req=1, iord=1, memwrite=1; hold until mem_ready=1, then FETCH.
REQ-023 EXEC: alusrca=1, alusrcb=00, aluop=10; then ALUWB.
REQ-024 ALUWB: regdst=1, memtoreg=0, regwrite=1; then FETCH.
REQ-025 BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1; then FETCH.
REQ-026 ADDIEX: alusrca=1, alusrcb=10, aluop=00; then ADDIWB.
REQ-027 ADDIWB: regdst=0, memtoreg=0, regwrite=1; then FETCH.
REQ-028 JUMP: pcsrc=10, pcwrite=1; then FETCH.
REQ-029 pcen SHALL equal pcwrite | (branch & zero), combinationally from the current cycle.
REQ-030 Any control not listed for a state SHALL be 0 in that state.
REQ-031 The wait counter SHALL clear on entry to FETCH, MEMRD and MEMWR, and increment each cycle spent waiting.
REQ-032 If the counter reaches TIMEOUT_CYC-1 with mem_ready=0:
- pulse mem_timeout for one cycle;
- go to FETCH;
- issue no irwrite, pcwrite, memwrite or regwrite in that cycle.
REQ-033 If mem_ready=1 in the same cycle the counter reaches its limit, the access completes normally and no timeout is reported.
REQ-034 memwrite SHALL stay asserted continuously throughout a MEMWR wait, with no toggling.
REQ-035 alucontrol SHALL be decoded from aluop and funct: 00 add, 01 sub, 10 funct-decoded.
REQ-036 Minimum instruction latency, with mem_ready tied to 1:
- 3 cycles: beq, j
- 4 cycles: R-type, addi, sw
- 5 cycles: lw

Reset
REQ-037 Asserting reset_n=0 SHALL force the FSM to FETCH and clear the counter immediately, regardless of the current state or any wait in progress.
REQ-038 While reset_n=0, every output SHALL be 0 except the FETCH Moore outputs; in particular pcen=0.
REQ-039 The first fetch request SHALL occur in the first cycle after reset_n is released.

Structure
REQ-040 The shared package SHALL define:
- the state enum;
- the opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J);
- the aluop and alucontrol encodings.
REQ-041 The block SHALL instantiate the existing aludec as its only sub-module; the FSM, counter and output decode stay in mc_controller.

Verification
REQ-042 The bench SHALL cover these scenarios:
- lw (op=100011), mem_ready=1: state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB; regwrite=1 with memtoreg=1 in cycle 5.
- beq, zero=1: pcen=1 with pcsrc=01 in cycle 3. Repeat with zero=0: pcen=0 in cycle 3.
- FETCH with mem_ready held low for 3 cycles: irwrite=0 throughout the wait, then irwrite=pcen=1 in the 4th cycle.
- MEMWR with mem_ready held low and TIMEOUT_CYC=16: mem_timeout pulses in the 16th cycle, followed by FETCH; no write is issued.
- op=111111: illegal_op pulses in DECODE, followed by FETCH; regwrite, memwrite and pcen stay 0.
- reset_n driven low mid-MEMRD: FETCH immediately (asynchronous); mem_req=1 and iord=0 in the first cycle after release.

Source files
------------

// File: rtl/mc_controller_pkg.sv
// Shared definitions for the multicycle controller.
// Holds the FSM state enum, opcode and funct constants, the aluop
// encoding handed to the ALU decoder and the alucontrol encoding
// understood by the datapath ALU.
package mc_controller_pkg;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [4:0] ALU_AND = 5'd0;
    localparam logic [4:0] ALU_OR  = 5'd1;
    localparam logic [4:0] ALU_ADD = 5'd2;
    localparam logic [4:0] ALU_SUB = 5'd6;
    localparam logic [4:0] ALU_SLT = 5'd7;

endpackage

// File: rtl/mc_controller_aludec.sv
// ALU decoder for the multicycle controller.
// Ports:
//   aluop      in  2  operation class chosen by the FSM
//   funct      in  6  R-type function field
//   alucontrol out 5  operation code for the datapath ALU
module aludec
    import mc_controller_pkg::*;
(
    input  aluop_t     aluop,
    input  logic [5:0] funct,
    output logic [4:0] alucontrol
);

    // Address arithmetic and addi use add, beq uses subtract, and only
    // R-type looks at funct. Unknown funct codes fall back to add so the
    // ALU never sees an undefined operation.
    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: alucontrol = ALU_ADD;
                    FUNCT_SUB: alucontrol = ALU_SUB;
                    FUNCT_AND: alucontrol = ALU_AND;
                    FUNCT_OR:  alucontrol = ALU_OR;
                    FUNCT_SLT: alucontrol = ALU_SLT;
                    default:   alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS-style controller: Moore FSM, memory wait counter with
// timeout, and datapath control decode.
// Ports:
//   clk, reset_n                 clock and async active-low reset
//   op, funct, zero, mem_ready   instruction fields, ALU flag, memory handshake
//   mem_req, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
//   alusrcb, pcsrc, pcen, alucontrol   datapath controls
//   illegal_op, mem_timeout      one-cycle error pulses
module mc_controller
    import mc_controller_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       pcen,
    output logic [4:0] alucontrol,
    output logic       illegal_op,
    output logic       mem_timeout
);

    localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT_CYC - 1);

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic          waiting;
    logic          timeout;
    logic          pcwrite;
    logic          branch;
    aluop_t        aluop;

    // A wait is any memory state whose access has not completed yet.
    // The timeout fires only on the last allowed cycle with no ready, so a
    // ready arriving on that same cycle still completes normally.
    assign waiting = (state == FETCH || state == MEMRD || state == MEMWR) && !mem_ready;
    assign timeout = reset_n && waiting && (cnt == CNT_LIMIT);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Wait counter. Any state change restarts it, which covers entry into
    // every memory state; a timeout in FETCH stays in FETCH, so it is
    // cleared explicitly for the retried fetch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (timeout || state_next != state) begin
            cnt <= '0;
        end else if (waiting) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            FETCH:  state_next = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_RTYPE:     state_next = EXEC;
                    OP_BEQ:       state_next = BRANCH;
                    OP_ADDI:      state_next = ADDIEX;
                    OP_J:         state_next = JUMP;
                    default:      state_next = FETCH;
                endcase
            end
            MEMADR: state_next = (op == OP_LW) ? MEMRD : MEMWR;
            MEMRD: begin
                if (mem_ready)    state_next = MEMWB;
                else if (timeout) state_next = FETCH;
            end
            MEMWB:  state_next = FETCH;
            MEMWR: begin
                if (mem_ready || timeout) state_next = FETCH;
            end
            EXEC:   state_next = ALUWB;
            ALUWB:  state_next = FETCH;
            BRANCH: state_next = FETCH;
            ADDIEX: state_next = ADDIWB;
            ADDIWB: state_next = FETCH;
            JUMP:   state_next = FETCH;
            default: state_next = FETCH;
        endcase
    end

    // Output decode. The FETCH write strobes are gated by reset_n so a
    // held reset with mem_ready high cannot load the IR or PC, and the
    // store strobe drops on the abandoning cycle of a timed-out write.
    always_comb begin
        mem_req    = 1'b0;
        iord       = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        aluop      = ALUOP_ADD;
        illegal_op = 1'b0;
        case (state)
            FETCH: begin
                mem_req = 1'b1;
                alusrcb = 2'b01;
                irwrite = mem_ready && reset_n;
                pcwrite = mem_ready && reset_n;
            end
            DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: illegal_op = 1'b0;
                    default: illegal_op = 1'b1;
                endcase
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            MEMWR: begin
                mem_req  = 1'b1;
                iord     = 1'b1;
                memwrite = !timeout;
            end
            EXEC: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
            end
            ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            BRANCH: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            ADDIWB: regwrite = 1'b1;
            JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: begin
                mem_req = 1'b0;
            end
        endcase
    end

    assign pcen        = pcwrite || (branch && zero);
    assign mem_timeout = timeout;

    aludec u_aludec (
        .aluop      (aluop),
        .funct      (funct),
        .alucontrol (alucontrol)
    );

endmodule

// File: tb/tb_mc_controller.sv
// Directed self-checking bench for mc_controller.
module tb_mc_controller;
    import mc_controller_pkg::*;

    logic       clk;
    logic       reset_n;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       pcen;
    logic [4:0] alucontrol;
    logic       illegal_op;
    logic       mem_timeout;

    int checks = 0;
    int errors = 0;

    mc_controller #(.TIMEOUT_CYC(16)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .op          (op),
        .funct       (funct),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .mem_req     (mem_req),
        .iord        (iord),
        .memwrite    (memwrite),
        .irwrite     (irwrite),
        .regdst      (regdst),
        .memtoreg    (memtoreg),
        .regwrite    (regwrite),
        .alusrca     (alusrca),
        .alusrcb     (alusrcb),
        .pcsrc       (pcsrc),
        .pcen        (pcen),
        .alucontrol  (alucontrol),
        .illegal_op  (illegal_op),
        .mem_timeout (mem_timeout)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic nextCycle();
        @(posedge clk);
        #2;
    endtask

    // Drive the inputs for the current cycle and let the comb logic settle.
    task automatic applyStimulus(input logic [5:0] o, input logic [5:0] f,
                                 input logic z, input logic r);
        op        = o;
        funct     = f;
        zero      = z;
        mem_ready = r;
        #1;
    endtask

    // Compare one observed value with its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Linear sequence of directed steps.
    initial begin
        reset_n = 1'b0;
        applyStimulus(OP_LW, 6'd0, 1'b0, 1'b1);
        nextCycle();
        nextCycle();

        // Held in reset with mem_ready high: only FETCH Moore outputs.
        applyStimulus(OP_LW, 6'd0, 1'b0, 1'b1);
        checkOutput("rst_state", dut.state, FETCH);
        checkOutput("rst_mem_req", mem_req, 1);
        checkOutput("rst_iord", iord, 0);
        checkOutput("rst_irwrite", irwrite, 0);
        checkOutput("rst_pcen", pcen, 0);
        checkOutput("rst_alusrcb", alusrcb, 1);
        checkOutput("rst_regwrite", regwrite, 0);

        // lw with mem_ready=1: FETCH, DECODE, MEMADR, MEMRD, MEMWB.
        reset_n = 1'b1;
        applyStimulus(OP_LW, 6'd0, 1'b0, 1'b1);
        checkOutput("lw1_state", dut.state, FETCH);
        checkOutput("lw1_mem_req", mem_req, 1);
        checkOutput("lw1_irwrite", irwrite, 1);
        checkOutput("lw1_pcen", pcen, 1);
        nextCycle();
        applyStimulus(OP_LW, 6'd0, 1'b0, 1'b1);
        checkOutput("lw2_state", dut.state, DECODE);
        checkOutput("lw2_alusrcb", alusrcb, 3);
        checkOutput("lw2_mem_req", mem_req, 0);
        nextCycle();
        applyStimulus(OP_LW, 6'd0, 1'b0, 1'b1);
        checkOutput("lw3_state", dut.state, MEMADR);
        checkOutput("lw3_alusrca", alusrca, 1);
        checkOutput("lw3_alusrcb", alusrcb, 2);
        nextCycle();
        applyStimulus(OP_LW, 6'd0, 1'b0, 1'b1);
        checkOutput("lw4_state", dut.state, MEMRD);
        checkOutput("lw4_iord", iord, 1);
        nextCycle();
        applyStimulus(OP_LW, 6'd0, 1'b0, 1'b1);
        checkOutput("lw5_state", dut.state, MEMWB);
        checkOutput("lw5_regwrite", regwrite, 1);
        checkOutput("lw5_memtoreg", memtoreg, 1);

        // beq taken.
        nextCycle();
        applyStimulus(OP_BEQ, 6'd0, 1'b1, 1'b1);
        checkOutput("beq1_state", dut.state, FETCH);
        nextCycle();
        applyStimulus(OP_BEQ, 6'd0, 1'b1, 1'b1);
        nextCycle();
        applyStimulus(OP_BEQ, 6'd0, 1'b1, 1'b1);
        checkOutput("beqt_state", dut.state, BRANCH);
        checkOutput("beqt_pcen", pcen, 1);
        checkOutput("beqt_pcsrc", pcsrc, 1);
        checkOutput("beqt_alucontrol", alucontrol, ALU_SUB);

        // beq not taken.
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            applyStimulus(OP_BEQ, 6'd0, 1'b0, 1'b1);
        end
        checkOutput("beqn_state", dut.state, BRANCH);
        checkOutput("beqn_pcen", pcen, 0);

        // R-type and.
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            applyStimulus(OP_RTYPE, FUNCT_AND, 1'b0, 1'b1);
        end
        checkOutput("r_exec_state", dut.state, EXEC);
        checkOutput("r_alucontrol", alucontrol, ALU_AND);
        checkOutput("r_alusrcb", alusrcb, 0);
        nextCycle();
        applyStimulus(OP_RTYPE, FUNCT_AND, 1'b0, 1'b1);
        checkOutput("r_wb_state", dut.state, ALUWB);
        checkOutput("r_regwrite", regwrite, 1);
        checkOutput("r_regdst", regdst, 1);

        // addi.
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            applyStimulus(OP_ADDI, 6'd0, 1'b0, 1'b1);
        end
        checkOutput("addi_ex_alusrcb", alusrcb, 2);
        checkOutput("addi_ex_alucontrol", alucontrol, ALU_ADD);
        nextCycle();
        applyStimulus(OP_ADDI, 6'd0, 1'b0, 1'b1);
        checkOutput("addi_wb_state", dut.state, ADDIWB);
        checkOutput("addi_wb_regwrite", regwrite, 1);
        checkOutput("addi_wb_regdst", regdst, 0);

        // j.
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            applyStimulus(OP_J, 6'd0, 1'b0, 1'b1);
        end
        checkOutput("j_state", dut.state, JUMP);
        checkOutput("j_pcen", pcen, 1);
        checkOutput("j_pcsrc", pcsrc, 2);

        // FETCH with mem_ready low for three cycles.
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            applyStimulus(6'b111111, 6'd0, 1'b0, 1'b0);
            checkOutput("fw_irwrite", irwrite, 0);
            checkOutput("fw_pcen", pcen, 0);
        end
        nextCycle();
        applyStimulus(6'b111111, 6'd0, 1'b0, 1'b1);
        checkOutput("fw4_irwrite", irwrite, 1);
        checkOutput("fw4_pcen", pcen, 1);

        // Illegal opcode decoded in DECODE.
        nextCycle();
        applyStimulus(6'b111111, 6'd0, 1'b0, 1'b1);
        checkOutput("ill_state", dut.state, DECODE);
        checkOutput("ill_pulse", illegal_op, 1);
        checkOutput("ill_regwrite", regwrite, 0);
        checkOutput("ill_memwrite", memwrite, 0);
        checkOutput("ill_pcen", pcen, 0);
        nextCycle();
        applyStimulus(OP_SW, 6'd0, 1'b0, 1'b1);
        checkOutput("ill_next_state", dut.state, FETCH);
        checkOutput("ill_cleared", illegal_op, 0);

        // sw that times out in MEMWR.
        nextCycle();
        applyStimulus(OP_SW, 6'd0, 1'b0, 1'b1);
        nextCycle();
        applyStimulus(OP_SW, 6'd0, 1'b0, 1'b1);
        checkOutput("sw_adr_state", dut.state, MEMADR);
        for (int i = 1; i <= 16; i++) begin
            nextCycle();
            applyStimulus(OP_SW, 6'd0, 1'b0, 1'b0);
            checkOutput("sw_wait_state", dut.state, MEMWR);
            if (i < 16) begin
                checkOutput("sw_wait_memwrite", memwrite, 1);
                checkOutput("sw_wait_timeout", mem_timeout, 0);
            end else begin
                checkOutput("sw_to_pulse", mem_timeout, 1);
                checkOutput("sw_to_memwrite", memwrite, 0);
            end
        end
        nextCycle();
        applyStimulus(OP_LW, 6'd0, 1'b0, 1'b1);
        checkOutput("sw_to_next_state", dut.state, FETCH);
        checkOutput("sw_to_cleared", mem_timeout, 0);
        checkOutput("sw_to_next_memwrite", memwrite, 0);

        // lw whose ready lands exactly on the limit cycle.
        nextCycle();
        applyStimulus(OP_LW, 6'd0, 1'b0, 1'b1);
        nextCycle();
        applyStimulus(OP_LW, 6'd0, 1'b0, 1'b1);
        for (int i = 1; i <= 15; i++) begin
            nextCycle();
            applyStimulus(OP_LW, 6'd0, 1'b0, 1'b0);
            checkOutput("lim_wait_timeout", mem_timeout, 0);
        end
        nextCycle();
        applyStimulus(OP_LW, 6'd0, 1'b0, 1'b1);
        checkOutput("lim_state", dut.state, MEMRD);
        checkOutput("lim_timeout", mem_timeout, 0);
        nextCycle();
        applyStimulus(OP_LW, 6'd0, 1'b0, 1'b1);
        checkOutput("lim_wb_state", dut.state, MEMWB);

        // Async reset during a MEMRD wait.
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            applyStimulus(OP_LW, 6'd0, 1'b0, 1'b1);
        end
        nextCycle();
        applyStimulus(OP_LW, 6'd0, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(OP_LW, 6'd0, 1'b0, 1'b0);
        checkOutput("ar_pre_state", dut.state, MEMRD);
        reset_n = 1'b0;
        #1;
        checkOutput("ar_state", dut.state, FETCH);
        checkOutput("ar_mem_req", mem_req, 1);
        checkOutput("ar_iord", iord, 0);
        checkOutput("ar_pcen", pcen, 0);
        nextCycle();
        reset_n = 1'b1;
        applyStimulus(OP_LW, 6'd0, 1'b0, 1'b0);
        checkOutput("ar_rel_state", dut.state, FETCH);
        checkOutput("ar_rel_mem_req", mem_req, 1);
        checkOutput("ar_rel_iord", iord, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
